// File: rtl/g10_rx_block_lock.sv
// 10GBASE-R receive block-lock controller: hunts for sync-header alignment via gearbox slips.
// Optional BER monitor enabled by defining G10_RX_HIBER_EN; otherwise hi_ber is tied low.
module g10_rx_block_lock #(
    parameter int unsigned SH_CNT_MAX   = 64,
    parameter int unsigned INV_CNT_MAX  = 16,
`ifdef G10_RX_HIBER_EN
    parameter int unsigned HIBER_WINDOW = 19531,
    parameter int unsigned HIBER_THRESH = 16,
`endif
    parameter int unsigned SLIP_WAIT    = 32
) (
    input  logic        clk_ref,
    input  logic        rst_ref,
    input  logic        hdr_vld,
    input  logic [1:0]  hdr,
    output logic        slip,
    output logic        block_lock,
    output logic [15:0] slip_cnt,
    output logic        hi_ber
);

    localparam int unsigned WaitW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam logic [6:0] ShMax  = 7'(SH_CNT_MAX);
    localparam logic [4:0] InvMax = 5'(INV_CNT_MAX);

    typedef enum logic [1:0] {StTest, StSlip, StWait} state_e;

    state_e             state_q, state_d;
    logic [6:0]         sh_q, sh_d, sh_inc;
    logic [4:0]         inv_q, inv_d, inv_inc;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               lock_q, lock_d;
    logic               slip_q, slip_d;
    logic [15:0]        slip_cnt_q, slip_cnt_d;
    logic               invalid;
    logic               acquire, drop;

    assign invalid = (hdr == 2'b00) || (hdr == 2'b11);

    // State and registered outputs
    always_ff @(posedge clk_ref) begin
        if (rst_ref) begin
            state_q    <= StTest;
            sh_q       <= '0;
            inv_q      <= '0;
            wait_q     <= '0;
            lock_q     <= 1'b0;
            slip_q     <= 1'b0;
            slip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            inv_q      <= inv_d;
            wait_q     <= wait_d;
            lock_q     <= lock_d;
            slip_q     <= slip_d;
            slip_cnt_q <= slip_cnt_d;
        end
    end

    // Next-state and header counters
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        inv_d   = inv_q;
        wait_d  = wait_q;
        acquire = 1'b0;
        drop    = 1'b0;
        sh_inc  = sh_q + 7'd1;
        inv_inc = inv_q + {4'd0, invalid};
        unique case (state_q)
            StTest: begin
                if (hdr_vld) begin
                    if (!lock_q) begin
                        if (invalid) begin
                            state_d = StSlip;
                            sh_d    = '0;
                            inv_d   = '0;
                        end else if (sh_inc == ShMax && inv_q == 5'd0) begin
                            acquire = 1'b1;
                            sh_d    = '0;
                            inv_d   = '0;
                        end else begin
                            sh_d  = sh_inc;
                            inv_d = inv_inc;
                        end
                    end else begin
                        // Drop-lock wins over a window completing on the same beat
                        if (inv_inc == InvMax) begin
                            drop    = 1'b1;
                            state_d = StSlip;
                            sh_d    = '0;
                            inv_d   = '0;
                        end else if (sh_inc == ShMax) begin
                            sh_d  = '0;
                            inv_d = '0;
                        end else begin
                            sh_d  = sh_inc;
                            inv_d = inv_inc;
                        end
                    end
                end
            end
            StSlip: begin
                wait_d  = WaitW'(SLIP_WAIT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (wait_q == '0) begin
                    state_d = StTest;
                    sh_d    = '0;
                    inv_d   = '0;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: begin
                state_d = StTest;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        lock_d     = lock_q;
        slip_d     = 1'b0;
        slip_cnt_d = slip_cnt_q;
        if (acquire) begin
            lock_d = 1'b1;
        end else if (drop) begin
            lock_d = 1'b0;
        end
        if (state_q == StSlip) begin
            slip_d = 1'b1;
            if (slip_cnt_q != 16'hFFFF) begin
                slip_cnt_d = slip_cnt_q + 16'd1;
            end
        end
    end

    assign slip       = slip_q;
    assign block_lock = lock_q;
    assign slip_cnt   = slip_cnt_q;

`ifdef G10_RX_HIBER_EN
    localparam logic [14:0] WinMax = 15'(HIBER_WINDOW);
    localparam logic [4:0]  ErrMax = 5'(HIBER_THRESH);

    logic [14:0] win_q, win_d, win_inc;
    logic [4:0]  err_q, err_d, err_inc;
    logic        hi_ber_q, hi_ber_d;

    always_ff @(posedge clk_ref) begin
        if (rst_ref) begin
            win_q    <= '0;
            err_q    <= '0;
            hi_ber_q <= 1'b0;
        end else begin
            win_q    <= win_d;
            err_q    <= err_d;
            hi_ber_q <= hi_ber_d;
        end
    end

    always_comb begin
        win_d    = win_q;
        err_d    = err_q;
        hi_ber_d = hi_ber_q;
        win_inc  = win_q + 15'd1;
        err_inc  = (invalid && err_q != 5'h1F) ? err_q + 5'd1 : err_q;
        if (!lock_q) begin
            win_d    = '0;
            err_d    = '0;
            hi_ber_d = 1'b0;
        end else if (hdr_vld && state_q != StWait) begin
            if (win_inc == WinMax) begin
                // Window closed: flag reflects only the window just ended
                win_d    = '0;
                err_d    = '0;
                hi_ber_d = (err_inc >= ErrMax);
            end else begin
                win_d = win_inc;
                err_d = err_inc;
                if (err_inc >= ErrMax) begin
                    hi_ber_d = 1'b1;
                end
            end
        end
    end

    assign hi_ber = hi_ber_q;
`else
    assign hi_ber = 1'b0;
`endif

endmodule

// File: tb/tb_g10_rx_block_lock.sv
// Directed self-checking bench for g10_rx_block_lock (default parameters).
module tb_g10_rx_block_lock;

    logic        clk_ref = 1'b0;
    logic        rst_ref = 1'b1;
    logic        hdr_vld = 1'b0;
    logic [1:0]  hdr     = 2'b01;
    logic        slip;
    logic        block_lock;
    logic [15:0] slip_cnt;
    logic        hi_ber;

    int checks   = 0;
    int failures = 0;

    g10_rx_block_lock dut (
        .clk_ref    (clk_ref),
        .rst_ref    (rst_ref),
        .hdr_vld    (hdr_vld),
        .hdr        (hdr),
        .slip       (slip),
        .block_lock (block_lock),
        .slip_cnt   (slip_cnt),
        .hi_ber     (hi_ber)
    );

    always #5 clk_ref = ~clk_ref;

    // Apply inputs for one edge, then sample outputs 1 time unit after it.
    task automatic step(input logic v, input logic [1:0] h);
        hdr_vld = v;
        hdr     = h;
        @(posedge clk_ref);
        #1;
    endtask

    task automatic do_reset();
        rst_ref = 1'b1;
        step(1'b0, 2'b01);
        rst_ref = 1'b0;
    endtask

    // 64 valid beats from a freshly cleared TEST state; lock must rise exactly after the 64th.
    task automatic acquire(input string name);
        logic early = 1'b0;
        logic slipped = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 2'b01);
            if (i < 63 && block_lock) early = 1'b1;
            if (slip) slipped = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            failures++; $display("FAIL %s_early_lock: got early=%b want 0", name, early);
        end
        checks++;
        if (block_lock !== 1'b1) begin
            failures++; $display("FAIL %s_lock: got %b want 1", name, block_lock);
        end
        checks++;
        if (slipped !== 1'b0) begin
            failures++; $display("FAIL %s_no_slip: got slip seen=%b want 0", name, slipped);
        end
    endtask

    // After the triggering beat: slip low in SLIP, high one cycle later, then low.
    task automatic expect_slip(input string name, input logic [15:0] cnt);
        checks++;
        if (slip !== 1'b0) begin
            failures++; $display("FAIL %s_slip_c1: got %b want 0", name, slip);
        end
        step(1'b0, 2'b01);
        checks++;
        if (slip !== 1'b1 || slip_cnt !== cnt) begin
            failures++;
            $display("FAIL %s_slip_c2: got slip=%b cnt=%0d want 1 %0d", name, slip, slip_cnt, cnt);
        end
        step(1'b0, 2'b01);
        checks++;
        if (slip !== 1'b0) begin
            failures++; $display("FAIL %s_slip_c3: got %b want 0", name, slip);
        end
    endtask

    // Invalid headers for the 31 remaining WAIT edges must all be ignored.
    task automatic ignore_wait(input string name);
        logic slipped = 1'b0;
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 2'b11);
            if (slip || block_lock) slipped = 1'b1;
        end
        checks++;
        if (slipped !== 1'b0) begin
            failures++; $display("FAIL %s_wait_ignore: got activity=%b want 0", name, slipped);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (block_lock !== 1'b0 || slip !== 1'b0 || slip_cnt !== 16'd0 || hi_ber !== 1'b0) begin
            failures++;
            $display("FAIL reset: got lock=%b slip=%b cnt=%0d hiber=%b want 0 0 0 0",
                     block_lock, slip, slip_cnt, hi_ber);
        end
    endtask

    task automatic test_lock();
        acquire("lock");
        checks++;
        if (slip_cnt !== 16'd0) begin
            failures++; $display("FAIL lock_slip_cnt: got %0d want 0", slip_cnt);
        end
    endtask

    task automatic test_slip();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        expect_slip("slip", 16'd1);
        ignore_wait("slip");
        acquire("relock");
    endtask

    task automatic test_lock_hold();
        logic lost = 1'b0;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 64; i++) begin
                step(1'b1, (i % 4 == 0 && i < 60) ? 2'b00 : 2'b10);
                if (!block_lock || slip) lost = 1'b1;
            end
        end
        checks++;
        if (lost !== 1'b0 || block_lock !== 1'b1) begin
            failures++; $display("FAIL hold_15: got lost=%b lock=%b want 0 1", lost, block_lock);
        end
        checks++;
        if (slip_cnt !== 16'd1) begin
            failures++; $display("FAIL hold_slip_cnt: got %0d want 1", slip_cnt);
        end
    endtask

    task automatic test_lock_drop();
        logic early = 1'b0;
        for (int i = 0; i < 31; i++) begin
            step(1'b1, (i % 2 == 0) ? 2'b11 : 2'b01);
            if (i < 30 && !block_lock) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0 || block_lock !== 1'b0) begin
            failures++; $display("FAIL drop_16: got early=%b lock=%b want 0 0", early, block_lock);
        end
        expect_slip("drop", 16'd2);
        ignore_wait("drop");
        acquire("drop_relock");
        // 16th invalid header lands on beat 64 of the window
        for (int i = 0; i < 64; i++) begin
            step(1'b1, (i >= 48) ? 2'b00 : 2'b01);
            if (i == 62 && !block_lock) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0 || block_lock !== 1'b0) begin
            failures++; $display("FAIL drop_at_64: got early=%b lock=%b want 0 0", early, block_lock);
        end
        expect_slip("drop64", 16'd3);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        for (int s = 0; s < 5; s++) begin
            step(1'b1, 2'b00);
            step(1'b0, 2'b01);
            if (s < 4) begin
                for (int i = 0; i < 32; i++) step(1'b0, 2'b01);
            end
        end
        for (int i = 0; i < 5; i++) step(1'b1, 2'b11);
        checks++;
        if (slip_cnt !== 16'd5) begin
            failures++; $display("FAIL wait_pre_cnt: got %0d want 5", slip_cnt);
        end
        do_reset();
        checks++;
        if (slip_cnt !== 16'd0 || block_lock !== 1'b0 || slip !== 1'b0) begin
            failures++;
            $display("FAIL wait_reset: got cnt=%0d lock=%b slip=%b want 0 0 0",
                     slip_cnt, block_lock, slip);
        end
        // Immediately back in TEST: lock comes after exactly 64 beats, no slip
        acquire("post_reset");
    endtask

    task automatic test_hiber();
`ifdef G10_RX_HIBER_EN
        do_reset();
        acquire("hiber_lock");
        for (int k = 0; k < 19531; k++) begin
            step(1'b1, (k % 64 == 0 && k <= 960) ? 2'b00 : 2'b01);
            if (k == 959) begin
                checks++;
                if (hi_ber !== 1'b0) begin
                    failures++; $display("FAIL hiber_pre: got %b want 0", hi_ber);
                end
            end
            if (k == 960) begin
                checks++;
                if (hi_ber !== 1'b1) begin
                    failures++; $display("FAIL hiber_rise: got %b want 1", hi_ber);
                end
            end
        end
        checks++;
        if (hi_ber !== 1'b1 || block_lock !== 1'b1) begin
            failures++; $display("FAIL hiber_win1: got hiber=%b lock=%b want 1 1", hi_ber, block_lock);
        end
        for (int k = 0; k < 19531; k++) begin
            step(1'b1, 2'b10);
            if (k == 19529) begin
                checks++;
                if (hi_ber !== 1'b1) begin
                    failures++; $display("FAIL hiber_hold: got %b want 1", hi_ber);
                end
            end
        end
        checks++;
        if (hi_ber !== 1'b0) begin
            failures++; $display("FAIL hiber_clear: got %b want 0", hi_ber);
        end
`else
        logic seen = 1'b0;
        do_reset();
        acquire("hiber_off_lock");
        for (int i = 0; i < 64; i++) begin
            step(1'b1, (i < 15) ? 2'b00 : 2'b01);
            if (hi_ber) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL hiber_tied: got %b want 0", seen);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_slip();
        test_lock_hold();
        test_lock_drop();
        test_reset_in_wait();
        test_hiber();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/g10_rx_block_lock.md
Name: g10_rx_block_lock

Overview:
- Receive-side 10GBASE-R block-lock controller, implementing the 802.3 Clause 49 lock state machine.
- Sits between the RX gearbox (32-bit PMA word to 66-bit block) and the descrambler/decoder in the clk_ref domain.
- Watches the 2-bit sync header of each gearbox block and commands the gearbox to bit-slip until header alignment is found.
- Reports block_lock and, optionally, hi_ber to the PCS receive path.

Parameters:
- SH_CNT_MAX, 64, headers per test window.
- INV_CNT_MAX, 16, invalid headers in a window that drop lock.
- SLIP_WAIT, 32, clk_ref cycles to ignore headers after a slip pulse, covering gearbox re-alignment latency. Minimum 1.
- HIBER_WINDOW, 19531, hdr_vld beats per BER window (125 us of blocks). Used only with G10_RX_HIBER_EN.
- HIBER_THRESH, 16, invalid headers in one window that raise hi_ber. Used only with G10_RX_HIBER_EN.

Ports:
- clk_ref, input, 1: PMA/PCS reference clock. This is the only clock.
- rst_ref, input, 1: synchronous, active-high reset.
- hdr_vld, input, 1: qualifies hdr. One beat per 66-bit block.
- hdr, input, 2: sync header of the current block.
- slip, output, 1: one-cycle pulse requesting a one-bit slip from the gearbox.
- block_lock, output, 1: the header boundary is locked.
- slip_cnt, output, 16: count of slip pulses issued. Saturates at 16'hFFFF.
- hi_ber, output, 1: high bit-error-rate flag. Tied 0 when G10_RX_HIBER_EN is not defined.

Behaviour:
- Valid header: hdr == 2'b01 or hdr == 2'b10. Invalid header: 2'b00 or 2'b11.
- Reset (rst_ref=1 on a clk_ref edge) sets:
  - state = TEST
  - sh_cnt = 0, inv_cnt = 0, wait_cnt = 0
  - block_lock = 0, slip = 0, slip_cnt = 0, hi_ber = 0
- Reset asserted mid-operation overrides every state, including an in-flight WAIT.
- All outputs are registered.
- States are TEST, SLIP and WAIT.
- TEST state: each hdr_vld beat increments sh_cnt (7-bit). An invalid header also increments inv_cnt (5-bit). Cycles without hdr_vld change nothing.
  - block_lock=0 and the beat is invalid: go to SLIP on the next edge. Counters clear.
  - block_lock=0, the beat is valid, and sh_cnt reaches SH_CNT_MAX with inv_cnt==0: block_lock=1 on the next edge. Counters clear. Stay in TEST.
  - block_lock=1 and the beat brings inv_cnt to INV_CNT_MAX: block_lock=0 and go to SLIP on the next edge. Counters clear.
  - block_lock=1 and sh_cnt reaches SH_CNT_MAX with inv_cnt<INV_CNT_MAX: counters clear and block_lock stays 1.
  - If both conditions complete on the same beat (64th header, 16th invalid), the drop-lock condition has priority.
- SLIP state, which lasts exactly one cycle:
  - slip=1 for that cycle.
  - slip_cnt increments, saturating.
  - wait_cnt loads SLIP_WAIT-1, then go to WAIT.
- WAIT state:
  - hdr_vld is ignored. Headers are not counted.
  - wait_cnt decrements each cycle. At 0, go to TEST with counters clear.
  - block_lock stays 0.
- Latencies:
  - From an invalid header beat while unlocked to the slip pulse: 2 cycles (one edge to SLIP, slip registered high in SLIP).
  - From the 64th valid header beat to block_lock rising: 1 cycle.
- Back-to-back hdr_vld on every cycle is supported with no throughput gaps.

Optional Feature:
- Macro G10_RX_HIBER_EN.
- Defined:
  - A 15-bit window counter counts hdr_vld beats in every state except WAIT.
  - A 5-bit saturating error counter counts invalid headers in the same beats.
  - When the error counter reaches HIBER_THRESH, hi_ber=1 on the next edge.
  - When the window counter reaches HIBER_WINDOW, both counters clear. hi_ber is then recomputed: it stays 1 only if the threshold was reached in the window just ended, otherwise it goes to 0.
  - block_lock=0 forces hi_ber=0 and clears both counters.
- Undefined: no counters are present and hi_ber is a constant 0.

Test Plan:
- Reset, then 64 consecutive hdr_vld beats with hdr=2'b01 -> block_lock=1 one cycle after the 64th beat. slip never pulses. slip_cnt=0.
- Unlocked, 10 beats of hdr=2'b01 then one beat of hdr=2'b11 -> a single-cycle slip pulse. slip_cnt=1. Headers sent during the next 32 cycles are ignored. A subsequent 64 valid beats give block_lock=1.
- Locked, 15 invalid beats spread within a 64-beat window -> block_lock stays 1. Counters restart after beat 64.
- Locked, 16 invalid beats within one window -> block_lock=0 the cycle after the 16th, followed by one slip pulse. If the 16th invalid beat is also beat 64, lock must still drop.
- rst_ref asserted for 1 cycle during WAIT with slip_cnt=5 -> next cycle state=TEST, slip_cnt=0, block_lock=0. No slip pulse is issued.
- With G10_RX_HIBER_EN, locked, 16 invalid headers (hdr=2'b00) within the first 19531 beats, spaced so lock is held -> hi_ber=1. A following window with 0 errors -> hi_ber=0 after that window closes.
